// File: rtl/multi_delay_timer_if.sv
// Channel signal bundle for multi_delay_timer: async request inputs in, registered OUT/BUSY back.
// The master side drives the requests, the slave side (the timer) drives OUT and BUSY.
interface multi_delay_timer_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [NUM_CH-1:0] EN_IN;
    logic [NUM_CH-1:0] DISABLE_IN;
    logic [NUM_CH-1:0] OUT;
    logic [NUM_CH-1:0] BUSY;

    modport master (
        output EN_IN,
        output DISABLE_IN,
        input  OUT,
        input  BUSY
    );

    modport slave (
        input  EN_IN,
        input  DISABLE_IN,
        output OUT,
        output BUSY
    );
endinterface

// File: rtl/multi_delay_timer.sv
// multi_delay_timer: per-channel power-sequencing delay timer fed by synchronised enable/disable requests.
// Optional macro DELAY_CASCADE_EN chains the channels: power-up runs 0..N-1, power-down N-1..0.
//
// state  | meaning
// IDLE   | OUT low, waiting for an enable rise
// ARM    | counting the assert delay, OUT still low
// ON     | OUT high
// DISARM | counting the deassert delay, OUT still high
module multi_delay_timer #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 25,
    parameter int unsigned ASSERT_DLY   = 32'h17D7840,
    parameter int unsigned DEASSERT_DLY = 32'h17D7840,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic               SYSCLK,
    input  logic               RESET_N,
    multi_delay_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ON     = 2'd2,
        DISARM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] A_LOAD = CNT_W'(ASSERT_DLY);
    localparam logic [CNT_W-1:0] D_LOAD = CNT_W'(DEASSERT_DLY);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_chk_num_ch
        $error("multi_delay_timer: NUM_CH must be in 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("multi_delay_timer: SYNC_STAGES must be at least 2");
    end
    if ((64'(ASSERT_DLY) >> CNT_W) != 64'd0) begin : g_chk_assert_dly
        $error("multi_delay_timer: ASSERT_DLY does not fit in CNT_W bits");
    end
    if ((64'(DEASSERT_DLY) >> CNT_W) != 64'd0) begin : g_chk_deassert_dly
        $error("multi_delay_timer: DEASSERT_DLY does not fit in CNT_W bits");
    end

    logic [NUM_CH-1:0] en_sync_q  [SYNC_STAGES];
    logic [NUM_CH-1:0] en_sync_d  [SYNC_STAGES];
    logic [NUM_CH-1:0] dis_sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] dis_sync_d [SYNC_STAGES];
    logic [NUM_CH-1:0] en_prev_q, en_prev_d;
    logic [NUM_CH-1:0] dis_prev_q, dis_prev_d;

    logic [NUM_CH-1:0] en_s, dis_s;
    logic [NUM_CH-1:0] en_rise, en_fall, dis_fall;
    logic [NUM_CH-1:0] hold_arm, hold_dis;

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] busy_q, busy_d;

    always_comb begin
        en_sync_d[0]  = bus.EN_IN;
        dis_sync_d[0] = bus.DISABLE_IN;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            en_sync_d[i]  = en_sync_q[i-1];
            dis_sync_d[i] = dis_sync_q[i-1];
        end
        en_prev_d  = en_s;
        dis_prev_d = dis_s;
    end

    assign en_s     = en_sync_q[SYNC_STAGES-1];
    assign dis_s    = dis_sync_q[SYNC_STAGES-1];
    assign en_rise  = en_s & ~en_prev_q;
    assign en_fall  = ~en_s & en_prev_q;
    assign dis_fall = ~dis_s & dis_prev_q;

`ifdef DELAY_CASCADE_EN
    // A channel may only count up once its lower neighbour is on, and down once its upper one is off.
    always_comb begin
        hold_arm = '0;
        hold_dis = '0;
        for (int k = 1; k < NUM_CH; k++) begin
            hold_arm[k] = ~out_q[k-1];
        end
        for (int k = 0; k < NUM_CH - 1; k++) begin
            hold_dis[k] = out_q[k+1];
        end
    end
`else
    assign hold_arm = '0;
    assign hold_dis = '0;
`endif

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                en_sync_q[i]  <= '0;
                dis_sync_q[i] <= '0;
            end
            en_prev_q  <= '0;
            dis_prev_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
            out_q  <= '0;
            busy_q <= '0;
        end else begin
            en_sync_q  <= en_sync_d;
            dis_sync_q <= dis_sync_d;
            en_prev_q  <= en_prev_d;
            dis_prev_q <= dis_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
        end
    end

    // Only the highest-priority pending event is considered; an ignored event still blocks lower ones.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (en_fall[k]) begin
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
            end else if (dis_fall[k] && state_q[k] == ON) begin
                state_d[k] = DISARM;
                cnt_d[k]   = D_LOAD;
            end else if (dis_fall[k] && state_q[k] == ARM) begin
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
            end else if (en_rise[k] && !dis_fall[k] && state_q[k] == IDLE) begin
                state_d[k] = ARM;
                cnt_d[k]   = A_LOAD;
            end else if (en_rise[k] && !dis_fall[k] && state_q[k] == DISARM) begin
                state_d[k] = ON;
                cnt_d[k]   = '0;
            end else if (state_q[k] == ARM && !hold_arm[k]) begin
                if (cnt_q[k] == '0) begin
                    state_d[k] = ON;
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
            end else if (state_q[k] == DISARM && !hold_dis[k]) begin
                if (cnt_q[k] == '0) begin
                    state_d[k] = IDLE;
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        out_d  = '0;
        busy_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_d[k]  = (state_d[k] == ON)  || (state_d[k] == DISARM);
            busy_d[k] = (state_d[k] == ARM) || (state_d[k] == DISARM);
        end
    end

    assign bus.OUT  = out_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Bench for multi_delay_timer: deadline-based reference model checked every cycle, plus literal edge checks.
// Build with or without DELAY_CASCADE_EN; expectations follow the macro.
module tb_multi_delay_timer;

    localparam int N    = 4;
    localparam int AD   = 10;
    localparam int DD   = 5;
    localparam int SS   = 2;
    localparam int HMAX = 4096;
`ifdef DELAY_CASCADE_EN
    localparam bit CASC = 1'b1;
`else
    localparam bit CASC = 1'b0;
`endif
    localparam int M_OFF = 0, M_ARMING = 1, M_ON = 2, M_DISARMING = 3;

    logic SYSCLK  = 1'b0;
    logic RESET_N = 1'b0;

    multi_delay_timer_if #(.NUM_CH(N)) bus ();
    multi_delay_timer_if #(.NUM_CH(1)) zbus ();

    multi_delay_timer #(
        .NUM_CH(N), .CNT_W(8), .ASSERT_DLY(AD), .DEASSERT_DLY(DD), .SYNC_STAGES(SS)
    ) dut (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .bus(bus)
    );

    multi_delay_timer #(
        .NUM_CH(1), .CNT_W(4), .ASSERT_DLY(0), .DEASSERT_DLY(0), .SYNC_STAGES(SS)
    ) dut_z (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .bus(zbus)
    );

    initial forever #5 SYSCLK = ~SYSCLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [N-1:0] en_h  [HMAX];
    logic [N-1:0] dis_h [HMAX];
    int mmode  [N];
    int t0     [N];
    int rise_t [N];
    int fall_t [N];
    logic [N-1:0] exp_out  = '0;
    logic [N-1:0] exp_busy = '0;

    function automatic logic h_en(input int t, input int k);
        if (t < 1) return 1'b0;
        return en_h[t][k];
    endfunction

    function automatic logic h_dis(input int t, input int k);
        if (t < 1) return 1'b0;
        return dis_h[t][k];
    endfunction

    // Reference: an event seen at edge t acts at edge t+2; a delay D ends D+1 edges after its start,
    // and in cascade mode the start is pushed back to when the neighbour's OUT changed.
    initial begin
        logic [N-1:0] prev_out;
        logic enr, enf, disf, ready;
        int g;
        for (int k = 0; k < N; k++) begin
            mmode[k] = M_OFF; t0[k] = 0; rise_t[k] = 0; fall_t[k] = 0;
        end
        forever begin
            @(posedge SYSCLK);
            cyc++;
            if (cyc >= HMAX) begin
                $display("FAIL cycle_budget actual=%0d required_below=%0d", cyc, HMAX);
                $fatal(1, "cycle budget exhausted");
            end
            prev_out = exp_out;
            if (!RESET_N) begin
                en_h[cyc]  = '0;
                dis_h[cyc] = '0;
                for (int k = 0; k < N; k++) mmode[k] = M_OFF;
            end else begin
                en_h[cyc]  = bus.EN_IN;
                dis_h[cyc] = bus.DISABLE_IN;
                for (int k = 0; k < N; k++) begin
                    enr  = h_en(cyc-2, k) & ~h_en(cyc-3, k);
                    enf  = ~h_en(cyc-2, k) & h_en(cyc-3, k);
                    disf = ~h_dis(cyc-2, k) & h_dis(cyc-3, k);
                    if (enf) begin
                        mmode[k] = M_OFF;
                    end else if (disf && mmode[k] == M_ON) begin
                        mmode[k] = M_DISARMING; t0[k] = cyc;
                    end else if (disf && mmode[k] == M_ARMING) begin
                        mmode[k] = M_OFF;
                    end else if (enr && !disf && mmode[k] == M_OFF) begin
                        mmode[k] = M_ARMING; t0[k] = cyc;
                    end else if (enr && !disf && mmode[k] == M_DISARMING) begin
                        mmode[k] = M_ON;
                    end else if (mmode[k] == M_ARMING) begin
                        ready = 1'b1; g = t0[k];
                        if (CASC && k > 0) begin
                            ready = prev_out[k-1];
                            if (rise_t[k-1] > g) g = rise_t[k-1];
                        end
                        if (ready && cyc >= g + AD + 1) mmode[k] = M_ON;
                    end else if (mmode[k] == M_DISARMING) begin
                        ready = 1'b1; g = t0[k];
                        if (CASC && k < N - 1) begin
                            ready = ~prev_out[k+1];
                            if (fall_t[k+1] > g) g = fall_t[k+1];
                        end
                        if (ready && cyc >= g + DD + 1) mmode[k] = M_OFF;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                exp_out[k]  = (mmode[k] == M_ON) || (mmode[k] == M_DISARMING);
                exp_busy[k] = (mmode[k] == M_ARMING) || (mmode[k] == M_DISARMING);
                if (exp_out[k] && !prev_out[k]) rise_t[k] = cyc;
                if (!exp_out[k] && prev_out[k]) fall_t[k] = cyc;
            end
        end
    end

    initial forever begin
        @(posedge SYSCLK);
        #1;
        checks++;
        if (bus.OUT !== exp_out || bus.BUSY !== exp_busy) begin
            failures++;
            $display("FAIL model_cmp edge=%0d OUT=%b BUSY=%b required OUT=%b BUSY=%b",
                     cyc, bus.OUT, bus.BUSY, exp_out, exp_busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic goto_edge(input int n);
        while (cyc < n) @(negedge SYSCLK);
    endtask

    task automatic step(input int k);
        goto_edge(cyc + k);
    endtask

    initial begin
        int n, m;
        logic [N-1:0] pat;
        bus.EN_IN       = '0;
        bus.DISABLE_IN  = '1;
        zbus.EN_IN      = '0;
        zbus.DISABLE_IN = '1;

        // reset held with EN toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge SYSCLK);
            bus.EN_IN = (i % 2 == 0) ? 4'hF : 4'h0;
        end
        chk("rst_out", 32'(bus.OUT), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        bus.EN_IN = '0;
        step(1);
        RESET_N = 1'b1;
        step(4);
        chk("post_rst_out", 32'(bus.OUT), 32'h0);
        chk("post_rst_busy", 32'(bus.BUSY), 32'h0);

        // assert / deassert on channel 0
        n = cyc;
        bus.EN_IN[0] = 1'b1;
        goto_edge(n + 2);  chk("a_busy_e2", 32'(bus.BUSY[0]), 32'h0);
        goto_edge(n + 3);  chk("a_busy_e3", 32'(bus.BUSY[0]), 32'h1);
        goto_edge(n + 13); chk("a_out_e13", 32'(bus.OUT[0]), 32'h0);
                           chk("a_busy_e13", 32'(bus.BUSY[0]), 32'h1);
        goto_edge(n + 14); chk("a_out_e14", 32'(bus.OUT[0]), 32'h1);
                           chk("a_busy_e14", 32'(bus.BUSY[0]), 32'h0);
        m = cyc;
        bus.DISABLE_IN[0] = 1'b0;
        goto_edge(m + 3);  chk("d_busy_e3", 32'(bus.BUSY[0]), 32'h1);
        goto_edge(m + 8);  chk("d_out_e8", 32'(bus.OUT[0]), 32'h1);
        goto_edge(m + 9);  chk("d_out_e9", 32'(bus.OUT[0]), 32'h0);
                           chk("d_busy_e9", 32'(bus.BUSY[0]), 32'h0);

        // bring channel 0 back on so later channels are not held in cascade builds
        bus.DISABLE_IN[0] = 1'b1;
        step(1);
        bus.EN_IN[0] = 1'b0;
        step(4);
        bus.EN_IN[0] = 1'b1;
        step(16);
        chk("ch0_on", 32'(bus.OUT[0]), 32'h1);

        // EN fall 3 cycles into ARM
        n = cyc;
        bus.EN_IN[1] = 1'b1;
        goto_edge(n + 5);
        bus.EN_IN[1] = 1'b0;
        goto_edge(n + 7);  chk("abort_busy_pre", 32'(bus.BUSY[1]), 32'h1);
        goto_edge(n + 8);  chk("abort_busy", 32'(bus.BUSY[1]), 32'h0);
        step(12);          chk("abort_out", 32'(bus.OUT[1]), 32'h0);

        // EN fall in ON
        n = cyc;
        bus.EN_IN[1] = 1'b1;
        goto_edge(n + 14); chk("ch1_on", 32'(bus.OUT[1]), 32'h1);
        m = cyc;
        bus.EN_IN[1] = 1'b0;
        goto_edge(m + 2);  chk("on_abort_e2", 32'(bus.OUT[1]), 32'h1);
        goto_edge(m + 3);  chk("on_abort_e3", 32'(bus.OUT[1]), 32'h0);

        // DISABLE fall in ARM aborts; OUT never rises
        step(3);
        n = cyc;
        bus.EN_IN[1] = 1'b1;
        goto_edge(n + 4);
        bus.DISABLE_IN[1] = 1'b0;
        goto_edge(n + 6);  chk("dis_arm_busy_pre", 32'(bus.BUSY[1]), 32'h1);
        goto_edge(n + 7);  chk("dis_arm_busy", 32'(bus.BUSY[1]), 32'h0);
        step(15);          chk("dis_arm_out", 32'(bus.OUT[1]), 32'h0);
        bus.DISABLE_IN[1] = 1'b1;
        bus.EN_IN[1] = 1'b0;
        step(4);

        // EN fall and DISABLE fall together in ON: EN fall wins
        n = cyc;
        bus.EN_IN[1] = 1'b1;
        bus.EN_IN[2] = 1'b1;
        goto_edge(n + 14 + (CASC ? AD + 1 : 0));
        chk("ch2_on", 32'(bus.OUT[2]), 32'h1);
        step(2);
        m = cyc;
        bus.EN_IN[2] = 1'b0;
        bus.DISABLE_IN[2] = 1'b0;
        goto_edge(m + 2);  chk("prio_out_e2", 32'(bus.OUT[2]), 32'h1);
        goto_edge(m + 3);  chk("prio_out_e3", 32'(bus.OUT[2]), 32'h0);
                           chk("prio_busy_e3", 32'(bus.BUSY[2]), 32'h0);
        bus.DISABLE_IN[2] = 1'b1;
        step(4);
        bus.DISABLE_IN[2] = 1'b0;
        step(6);
        chk("dis_idle_out", 32'(bus.OUT[2]), 32'h0);
        bus.DISABLE_IN[2] = 1'b1;
        bus.EN_IN = '0;
        step(6);

        // reset asserted mid-count
        n = cyc;
        bus.EN_IN[0] = 1'b1;
        goto_edge(n + 6);
        chk("mid_busy_pre", 32'(bus.BUSY[0]), 32'h1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_out", 32'(bus.OUT), 32'h0);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'h0);
        step(2);
        bus.EN_IN = '0;
        RESET_N = 1'b1;
        step(4);

        // all channels together: power-up then power-down ordering
        n = cyc;
        bus.EN_IN = '1;
        for (int e = n + 13; e <= n + 15 + 3 * (AD + 1); e++) begin
            goto_edge(e);
            for (int k = 0; k < N; k++) pat[k] = (e >= n + 14 + (CASC ? (AD + 1) * k : 0));
            chk("pwr_up", 32'(bus.OUT), 32'(pat));
        end
        m = cyc;
        bus.DISABLE_IN = '0;
        for (int e = m + 8; e <= m + 10 + 3 * (DD + 1); e++) begin
            goto_edge(e);
            for (int k = 0; k < N; k++) pat[k] = (e < m + 9 + (CASC ? (DD + 1) * (N - 1 - k) : 0));
            chk("pwr_down", 32'(bus.OUT), 32'(pat));
        end

        // zero delays
        n = cyc;
        zbus.EN_IN = 1'b1;
        goto_edge(n + 3);  chk("z_out_e3", 32'(zbus.OUT), 32'h0);
                           chk("z_busy_e3", 32'(zbus.BUSY), 32'h1);
        goto_edge(n + 4);  chk("z_out_e4", 32'(zbus.OUT), 32'h1);
                           chk("z_busy_e4", 32'(zbus.BUSY), 32'h0);
        goto_edge(n + 20); chk("z_out_hold", 32'(zbus.OUT), 32'h1);
                           chk("z_busy_hold", 32'(zbus.BUSY), 32'h0);
        m = cyc;
        zbus.DISABLE_IN = 1'b0;
        goto_edge(m + 3);  chk("z_dis_out_e3", 32'(zbus.OUT), 32'h1);
                           chk("z_dis_busy_e3", 32'(zbus.BUSY), 32'h1);
        goto_edge(m + 4);  chk("z_dis_out_e4", 32'(zbus.OUT), 32'h0);
                           chk("z_dis_busy_e4", 32'(zbus.BUSY), 32'h0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
